mux_rr_nch: RTL and testbench

//  N-channel, W-bit packet multiplexer for the transmit path. Generalises the 2:1 select mux.

---
 rtl/mux_rr_nch.sv | 102 ++++++++++
 tb/tb_mux_rr_nch.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_nch.sv
// N-channel packet multiplexer with round-robin arbitration, packet locking and a
// registered valid/ready output stage.
module mux_rr_nch #(
    parameter int W    = 8,
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic            out_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SELW-1:0] sel,
    output logic            busy
);

    localparam int unsigned NU = N;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] lock;
    logic [SELW-1:0] gnt;
    logic [SELW-1:0] gnt_nxt;
    logic            gnt_vld;
    logic            cap;
    logic            take;

    // Rotating search starting at ptr; indices wrap at N, not at 2**SELW.
    always_comb begin : arb
        logic            found;
        logic [SELW-1:0] cand;
        int unsigned     idx;
        found   = 1'b0;
        cand    = '0;
        idx     = 0;
        gnt     = ptr;
        gnt_vld = 1'b0;
        if (state == LOCKED) begin
            gnt     = lock;
            gnt_vld = in_valid[lock];
        end else begin
            for (int unsigned k = 0; k < NU; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NU) begin
                    idx = idx - NU;
                end
                cand = SELW'(idx);
                if (!found && in_valid[cand]) begin
                    found = 1'b1;
                    gnt   = cand;
                end
            end
            gnt_vld = found;
        end
    end

    assign cap     = ~out_valid | out_ready;
    // Nothing is accepted while reset is asserted, so no beat is lost to it.
    assign take    = gnt_vld & cap & rst_n;
    assign gnt_nxt = (gnt == SELW'(N - 1)) ? '0 : gnt + 1'b1;
    assign sel     = gnt;
    assign busy    = (state == LOCKED);

    always_comb begin
        in_ready = '0;
        if (take) begin
            in_ready[gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            lock      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (cap) begin
            out_valid <= take;
            if (take) begin
                out_data <= in_data[int'(gnt) * W +: W];
                out_last <= in_last[gnt];
                if (in_last[gnt]) begin
                    state <= IDLE;
                    ptr   <= gnt_nxt;
                end else begin
                    state <= LOCKED;
                    lock  <= gnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_nch.sv
// Bench for mux_rr_nch: directed scenarios with literal expectations plus a long
// randomized run, all cross-checked every cycle against a behavioural model.
module tb_mux_rr_nch;

    localparam int W    = 8;
    localparam int N    = 4;
    localparam int SELW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*W-1:0]  in_data = '0;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_last = '0;
    logic [N-1:0]    in_ready;
    logic [W-1:0]    out_data;
    logic            out_last;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [SELW-1:0] sel;
    logic            busy;

    int vectors = 0;
    int miscompares = 0;

    // behavioural model state
    bit         model_ok = 0;
    int         m_ptr = 0;
    int         m_owner = -1;
    logic       mo_valid = 1'b0;
    logic [7:0] mo_data = '0;
    logic       mo_last = 1'b0;
    logic [8:0] sb[$];
    int         acc_ch = -1;

    // random sources
    int         rem[N];
    logic [7:0] cd[N];
    bit         cl[N];

    always #5 clk = ~clk;

    mux_rr_nch #(.W(W), .N(N), .SELW(SELW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .sel(sel), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: whoever owns an unfinished packet keeps the output; otherwise the first
    // valid channel at or after ptr (mod N) wins. Finishing a packet moves ptr past it.
    always @(negedge clk) begin : cmp
        int         g;
        bit         gv;
        bit         capm;
        bit         acc;
        logic [31:0] expb;
        acc_ch = -1;
        if (!rst_n) begin
            chk("rst_in_ready", in_ready, 0);
            m_ptr    = 0;
            m_owner  = -1;
            mo_valid = 1'b0;
            mo_data  = '0;
            mo_last  = 1'b0;
            sb.delete();
            model_ok = 1;
        end else if (model_ok) begin
            capm = !mo_valid || out_ready;
            gv   = 0;
            g    = m_ptr;
            if (m_owner >= 0) begin
                g  = m_owner;
                gv = in_valid[g];
            end else begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (!gv && in_valid[c]) begin
                        gv = 1;
                        g  = c;
                    end
                end
            end
            acc = gv && capm;
            chk("in_ready", in_ready, acc ? (32'd1 << g) : 32'd0);
            chk("busy", busy, m_owner >= 0);
            if (gv) chk("sel", sel, g);
            chk("out_valid", out_valid, mo_valid);
            if (mo_valid) begin
                chk("out_data", out_data, mo_data);
                chk("out_last", out_last, mo_last);
            end
            if (out_valid && out_ready) begin
                expb = (sb.size() != 0) ? 32'(sb.pop_front()) : 32'hdead;
                chk("stream", {out_last, out_data}, expb);
            end
            if (capm) begin
                mo_valid = acc;
                if (acc) begin
                    mo_data = in_data[g*W +: W];
                    mo_last = in_last[g];
                end
            end
            if (acc) begin
                sb.push_back({in_last[g], in_data[g*W +: W]});
                acc_ch = g;
                if (in_last[g]) begin
                    m_owner = -1;
                    m_ptr   = (g + 1) % N;
                end else begin
                    m_owner = g;
                end
            end
        end
    end

    task automatic drive(input int ch, input bit v, input logic [7:0] d, input bit l);
        in_valid[ch]       = v;
        in_data[ch*W +: W] = d;
        in_last[ch]        = l;
    endtask

    task automatic all_singles(input logic [7:0] base);
        for (int i = 0; i < N; i++) drive(i, 1'b1, base + 8'(i), 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; out_ready = 1'b1; in_valid = '1; in_last = '1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = '0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sel", sel, 0);
        chk("rst_out_data", out_data, 0);
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic t4(input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1,
                      input bit l1, input logic [3:0] er, input bit eb, input bit eov,
                      input logic [7:0] eod);
        cyc();
        drive(0, v0, d0, 1'b1);
        drive(1, v1, d1, l1);
        @(negedge clk);
        chk("t4_ready", in_ready, er);
        chk("t4_busy", busy, eb);
        chk("t4_out_valid", out_valid, eov);
        if (eov) chk("t4_out_data", out_data, eod);
    endtask

    task automatic new_beat(input int i);
        if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
        cd[i] = 8'($urandom);
        cl[i] = (rem[i] == 1);
    endtask

    initial begin
        // 1) reset with every channel requesting
        do_reset();

        // 2) single beat from ch2
        cyc(); drive(2, 1'b1, 8'hA5, 1'b1);
        @(negedge clk); chk("t2_ready", in_ready, 4'b0100);
        cyc(); in_valid = '0;
        @(negedge clk);
        chk("t2_out_valid", out_valid, 1);
        chk("t2_out_data", out_data, 8'hA5);
        chk("t2_out_last", out_last, 1);
        cyc(); all_singles(8'h10);
        @(negedge clk); chk("t2_ptr_after", sel, 3);

        // 3) fair rotation of single-beat packets
        do_reset();
        cyc(); all_singles(8'h10);
        for (int c = 0; c < 9; c++) begin
            if (c > 0) cyc();
            @(negedge clk);
            chk("t3_sel", sel, c % 4);
            if (c > 0) chk("t3_out_data", out_data, 8'h10 + 8'((c - 1) % 4));
        end

        // 4) multi-beat lock with a bubble
        do_reset();
        t4(1, 8'h55, 0, 8'h00, 0, 4'b0001, 0, 0, 8'h00);
        t4(1, 8'h66, 1, 8'h01, 0, 4'b0010, 0, 1, 8'h55);
        t4(1, 8'h66, 1, 8'h02, 0, 4'b0010, 1, 1, 8'h01);
        t4(1, 8'h66, 0, 8'h02, 0, 4'b0000, 1, 1, 8'h02);
        t4(1, 8'h66, 1, 8'h03, 1, 4'b0010, 1, 0, 8'h00);
        t4(1, 8'h66, 0, 8'h03, 1, 4'b0001, 0, 1, 8'h03);
        t4(0, 8'h66, 0, 8'h03, 1, 4'b0000, 0, 1, 8'h66);

        // 5) backpressure holds the output and blocks all inputs
        do_reset();
        cyc(); all_singles(8'h10);
        @(negedge clk); chk("t5_ready0", in_ready, 4'b0001);
        for (int s = 0; s < 5; s++) begin
            cyc(); out_ready = 1'b0;
            @(negedge clk);
            chk("t5_stall_ready", in_ready, 0);
            chk("t5_stall_data", out_data, 8'h10);
            chk("t5_stall_last", out_last, 1);
            chk("t5_stall_valid", out_valid, 1);
        end
        cyc(); out_ready = 1'b1;
        @(negedge clk);
        chk("t5_release_data", out_data, 8'h10);
        chk("t5_release_ready", in_ready, 4'b0010);
        cyc();
        @(negedge clk); chk("t5_next_data", out_data, 8'h11);

        // 6) reset in the middle of a locked packet
        do_reset();
        cyc(); drive(2, 1'b1, 8'hB1, 1'b0);
        @(negedge clk); chk("t6_ready0", in_ready, 4'b0100);
        cyc(); drive(2, 1'b1, 8'hB2, 1'b0);
        @(negedge clk); chk("t6_busy1", busy, 1);
        cyc(); rst_n = 1'b0; drive(2, 1'b1, 8'hB3, 1'b0);
        @(negedge clk); chk("t6_rst_ready", in_ready, 0);
        cyc(); rst_n = 1'b1;
        drive(0, 1'b1, 8'h20, 1'b1); drive(1, 1'b1, 8'h21, 1'b1); drive(3, 1'b1, 8'h23, 1'b1);
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_sel", sel, 0);
        chk("t6_ready", in_ready, 4'b0001);

        // randomized packets, bubbles and backpressure
        do_reset();
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            new_beat(i);
        end
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if (acc_ch >= 0) begin
                rem[acc_ch]--;
                new_beat(acc_ch);
            end
            for (int i = 0; i < N; i++) drive(i, $urandom_range(0, 9) < 7, cd[i], cl[i]);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        cyc(); in_valid = '0; out_ready = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        chk("sb_drain", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
